// File: rtl/booth_pkg.sv
// Shared types for the radix-4 Booth multiplier: FSM states, the recoded
// digit flags, and the iteration-count helper.
package booth_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CALC,
    ST_DONE
  } state_t;

  // Radix-4 Booth digit in {0, +-1, +-2}: magnitude 2 when two=1, sign from neg.
  typedef struct packed {
    logic zero;
    logic neg;
    logic two;
  } booth_digit_t;

  function automatic int calc_iters(input int width);
    return width / 2 + 1;
  endfunction

endpackage

// File: rtl/booth_r4_enc.sv
// Combinational radix-4 Booth recoder: {b[i+1], b[i], b[i-1]} -> digit flags.
module booth_r4_enc
  import booth_pkg::*;
(
  input  logic [2:0]   triplet,
  output booth_digit_t digit
);

  always_comb begin
    digit      = '0;
    digit.zero = (triplet == 3'b000) || (triplet == 3'b111);
    digit.neg  = triplet[2] && !digit.zero;
    digit.two  = (triplet == 3'b011) || (triplet == 3'b100);
  end

endmodule

// File: rtl/booth_mult_r4.sv
// Sequential radix-4 Booth multiplier with valid/ready on both sides; one
// Booth step per cycle, result held in DONE until the consumer accepts it.
module booth_mult_r4
  import booth_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 tc,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   M,
  output logic                 busy
);

  localparam int E  = WIDTH + 2;
  localparam int HW = E + 2;
  localparam int N  = calc_iters(WIDTH);
  localparam int CW = $clog2(N + 1);

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic            tc_q, tc_d;
  logic [HW-1:0]   hi_q, hi_d;
  logic [E-1:0]    lo_q, lo_d;
  logic            prev_q, prev_d;
  logic            in_ready_q, in_ready_d;
  logic            out_valid_q, out_valid_d;
  logic            busy_q, busy_d;

  booth_digit_t    digit;
  logic [HW-1:0]   a_ext, pp_mag, pp, sum;
  logic signed [HW+E-1:0] shift_all;

  booth_r4_enc u_enc (
    .triplet ({lo_q[1], lo_q[0], prev_q}),
    .digit   (digit)
  );

  // The latched tc decides how the multiplicand is widened for the adder.
  assign a_ext  = tc_q ? {{(HW-WIDTH){a_q[WIDTH-1]}}, a_q} : {{(HW-WIDTH){1'b0}}, a_q};
  assign pp_mag = digit.zero ? '0 : (digit.two ? {a_ext[HW-2:0], 1'b0} : a_ext);
  assign pp     = digit.neg ? (~pp_mag + HW'(1)) : pp_mag;
  assign sum    = hi_q + pp;
  assign shift_all = $signed({sum, lo_q}) >>> 2;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    tc_d    = tc_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    prev_d  = prev_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          a_d     = A;
          tc_d    = tc;
          lo_d    = tc ? {{2{B[WIDTH-1]}}, B} : {2'b00, B};
          hi_d    = '0;
          prev_d  = 1'b0;
          cnt_d   = '0;
          state_d = ST_CALC;
        end
      end
      ST_CALC: begin
        hi_d   = shift_all[HW+E-1:E];
        lo_d   = shift_all[E-1:0];
        prev_d = lo_q[1];
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == CW'(N - 1)) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Handshake outputs are decoded from the next state and registered.
    in_ready_d  = (state_d == ST_IDLE);
    out_valid_d = (state_d == ST_DONE);
    busy_d      = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      a_q         <= '0;
      tc_q        <= 1'b0;
      hi_q        <= '0;
      lo_q        <= '0;
      prev_q      <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      a_q         <= a_d;
      tc_q        <= tc_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      prev_q      <= prev_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  // After N double-shifts the product is right-aligned across hi:lo.
  assign M         = {hi_q[WIDTH-3:0], lo_q};

endmodule
